gearbox_upsizing_nx: RTL

//  AXI-Stream width upsizer: packs RATIO consecutive DATA_W-bit input beats into one

---
 rtl/gearbox_upsizing_nx.sv | 107 ++++++++++
 1 files changed

// File: rtl/gearbox_upsizing_nx.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide word,
// flushing a partial word on in_tlast and marking filled lanes in out_tkeep.
module gearbox_upsizing_nx #(
    parameter int DATA_W = 40,
    parameter int RATIO  = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [DATA_W-1:0]         in_tdata,
    input  logic                      in_tvalid,
    input  logic                      in_tlast,
    output logic                      in_tready,
    output logic [DATA_W*RATIO-1:0]   out_tdata,
    output logic [RATIO-1:0]          out_tkeep,
    output logic                      out_tlast,
    output logic                      out_tvalid,
    input  logic                      out_tready
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int OW = DATA_W * RATIO;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [OW-1:0]    acc_q,   acc_d;
    logic [RATIO-1:0] keep_q,  keep_d;
    logic [OW-1:0]    data_q,  data_d;
    logic [RATIO-1:0] tkeep_q, tkeep_d;
    logic             last_q,  last_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             close;
    logic [OW-1:0]    acc_wr;
    logic [RATIO-1:0] keep_wr;

    assign in_tready = aresetn & (~valid_q | out_tready);
    assign accept    = in_tvalid & in_tready;
    assign close     = accept & ((cnt_q == LAST_LANE) | in_tlast);

    // Accumulator and keep mask with the incoming beat merged into lane cnt.
    always_comb begin
        acc_wr  = acc_q;
        keep_wr = keep_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (cnt_q == CW'(i)) begin
                acc_wr[i*DATA_W +: DATA_W] = in_tdata;
                keep_wr[i]                 = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        keep_d  = keep_q;
        data_d  = data_q;
        tkeep_d = tkeep_q;
        last_d  = last_q;
        valid_d = valid_q;

        if (valid_q && out_tready) begin
            valid_d = 1'b0;
        end

        // A closing beat may land on the same edge the previous word leaves.
        if (close) begin
            data_d  = acc_wr;
            tkeep_d = keep_wr;
            last_d  = in_tlast;
            valid_d = 1'b1;
            acc_d   = '0;
            keep_d  = '0;
            cnt_d   = '0;
        end else if (accept) begin
            acc_d   = acc_wr;
            keep_d  = keep_wr;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            keep_q  <= '0;
            data_q  <= '0;
            tkeep_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            keep_q  <= keep_d;
            data_q  <= data_d;
            tkeep_q <= tkeep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_tdata  = data_q;
    assign out_tkeep  = tkeep_q;
    assign out_tlast  = last_q;
    assign out_tvalid = valid_q;

endmodule
